adc_channel_sequencer: RTL and testbench

ADC_CHANNEL_SEQUENCER -- requirements
Module: adc_channel_sequencer

---
 rtl/adc_pkg.sv | 15 +
 rtl/adc_next_ch.sv | 27 ++
 rtl/adc_channel_sequencer.sv | 157 +++++++++++++++
 tb/tb_adc_channel_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC channel sequencer: FSM encoding and index width helper.
package adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_OUTPUT  = 2'd3
  } state_t;

  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/adc_next_ch.sv
// Finds the lowest set mask bit above (or, with incl, at or above) a given channel index.
module adc_next_ch
  import adc_pkg::*;
#(
  parameter int NUM_CH = 10,
  parameter int IDX_W  = ch_idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [IDX_W-1:0]  from,
  input  logic              incl,
  output logic [IDX_W-1:0]  ch,
  output logic              found
);

  // Descending scan so the lowest qualifying index is the last one written.
  always_comb begin
    ch    = '0;
    found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && ((i > int'(from)) || (incl && (i == int'(from))))) begin
        ch    = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_channel_sequencer.sv
// Scans enabled analog mux channels: settle, trigger conversion, hand off each sample.
// state   | meaning
// IDLE    | waiting for start with a non-zero enable mask
// SETTLE  | mux selected, settle down-counter running
// CONVERT | conversion in flight, waiting for conv_done
// OUTPUT  | mux released, sample held until out_ready
module adc_channel_sequencer
  import adc_pkg::*;
#(
  parameter int NUM_CH     = 10,
  parameter int DATA_W     = 12,
  parameter int SETTLE_CYC = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        continuous,
  input  logic [NUM_CH-1:0]           ch_enable,
  input  logic                        conv_done,
  input  logic [DATA_W-1:0]           adc_data,
  output logic [NUM_CH-1:0]           chan_sel,
  output logic                        conv_start,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [ch_idx_w(NUM_CH)-1:0] out_ch,
  output logic                        busy
);

  localparam int          IDX_W     = ch_idx_w(NUM_CH);
  localparam logic [7:0]  SETTLE_LD = 8'(SETTLE_CYC);

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [IDX_W-1:0]    cur_q, cur_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [IDX_W-1:0]    och_q, och_d;
  logic                cs_q, cs_d;

  logic [IDX_W-1:0]    nxt_ch, first_ch;
  logic                nxt_found, first_found;

  adc_next_ch #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_next (
    .mask  (mask_q),
    .from  (cur_q),
    .incl  (1'b0),
    .ch    (nxt_ch),
    .found (nxt_found)
  );

  adc_next_ch #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_first (
    .mask  (ch_enable),
    .from  ('0),
    .incl  (1'b1),
    .ch    (first_ch),
    .found (first_found)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    cur_d   = cur_q;
    valid_d = valid_q;
    data_d  = data_q;
    och_d   = och_q;
    cs_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && first_found) begin
          mask_d  = ch_enable;
          cur_d   = first_ch;
          cnt_d   = SETTLE_LD;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q <= 8'd1) begin
          cnt_d   = '0;
          cs_d    = 1'b1;
          state_d = ST_CONVERT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_CONVERT: begin
        // cs_q marks the conv_start cycle; a done strobe there belongs to an older conversion.
        if (conv_done && !cs_q) begin
          data_d  = adc_data;
          och_d   = cur_q;
          valid_d = 1'b1;
          state_d = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          if (nxt_found) begin
            cur_d   = nxt_ch;
            cnt_d   = SETTLE_LD;
            state_d = ST_SETTLE;
          end else if (continuous && first_found) begin
            mask_d  = ch_enable;
            cur_d   = first_ch;
            cnt_d   = SETTLE_LD;
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      cs_d    = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      cur_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      och_q   <= '0;
      cs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      cur_q   <= cur_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      och_q   <= och_d;
      cs_q    <= cs_d;
    end
  end

  assign chan_sel   = ((state_q == ST_SETTLE) || (state_q == ST_CONVERT))
                      ? (NUM_CH'(1) << cur_q) : '0;
  assign conv_start = cs_q;
  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_ch     = och_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adc_channel_sequencer.sv
// Directed bench for adc_channel_sequencer with hand-computed expectations.
module tb_adc_channel_sequencer;

  localparam int NUM_CH = 10;
  localparam int DATA_W = 12;

  logic              clk = 1'b0;
  logic              rst_n, start, abort, continuous, conv_done, out_ready;
  logic [NUM_CH-1:0] ch_enable;
  logic [DATA_W-1:0] adc_data;
  logic [NUM_CH-1:0] chan_sel;
  logic              conv_start, out_valid, busy;
  logic [DATA_W-1:0] out_data;
  logic [3:0]        out_ch;

  int n_chk  = 0;
  int n_fail = 0;

  adc_channel_sequencer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .SETTLE_CYC(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .continuous (continuous),
    .ch_enable  (ch_enable),
    .conv_done  (conv_done),
    .adc_data   (adc_data),
    .chan_sel   (chan_sel),
    .conv_start (conv_start),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ch     (out_ch),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_conv_start(input string tag);
    int n = 0;
    while (conv_start !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_conv_start_seen"}, 32'(n < 100), 32'd1);
  endtask

  // Waits for conv_start, returns the sample lat cycles later, leaves the bench in OUTPUT.
  task automatic do_conv(input string tag, input logic [DATA_W-1:0] d, input int lat);
    wait_conv_start(tag);
    repeat (lat) @(negedge clk);
    conv_done = 1'b1;
    adc_data  = d;
    @(negedge clk);
    conv_done = 1'b0;
  endtask

  task automatic pulse_start(input logic [NUM_CH-1:0] m);
    ch_enable = m;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; continuous = 1'b0;
    conv_done = 1'b0; out_ready = 1'b1; ch_enable = '0; adc_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_chan_sel", 32'(chan_sel), 32'h0);
    chk("rst_conv_start", 32'(conv_start), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_ch", 32'(out_ch), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero mask start is ignored; abort beats a coincident start
    pulse_start('0);
    chk("zero_mask_busy", 32'(busy), 32'h0);
    abort = 1'b1;
    pulse_start(10'b0000000001);
    abort = 1'b0;
    chk("abort_beats_start_busy", 32'(busy), 32'h0);

    // Single channel 3: conv_start latency, select hold, ignored strobes, stalled output
    pulse_start(10'b0000001000);
    n = 1;
    chk("c1_busy", 32'(busy), 32'h1);
    chk("c1_chan_sel", 32'(chan_sel), 32'h008);
    while (conv_start !== 1'b1 && n < 20) begin
      if (n == 2) begin start = 1'b1; ch_enable = 10'b0000000001; end
      @(negedge clk);
      n++;
      start = 1'b0;
      chk("settle_chan_sel", 32'(chan_sel), 32'h008);
    end
    chk("conv_start_latency", 32'(n), 32'd5);
    conv_done = 1'b1; adc_data = 12'hABC; out_ready = 1'b0;
    @(negedge clk);
    conv_done = 1'b0;
    chk("done_in_start_cycle_ignored", 32'(out_valid), 32'h0);
    chk("convert_chan_sel", 32'(chan_sel), 32'h008);
    chk("conv_start_one_cycle", 32'(conv_start), 32'h0);
    conv_done = 1'b1; adc_data = 12'h5A5;
    @(negedge clk);
    conv_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("stall_valid", 32'(out_valid), 32'h1);
      chk("stall_data", 32'(out_data), 32'h5A5);
      chk("stall_ch", 32'(out_ch), 32'd3);
      chk("stall_chan_sel", 32'(chan_sel), 32'h0);
      if (i == 5) begin conv_done = 1'b1; adc_data = 12'h0F0; end
      else conv_done = 1'b0;
      @(negedge clk);
    end
    conv_done = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("single_done_valid", 32'(out_valid), 32'h0);
    chk("single_done_busy", 32'(busy), 32'h0);

    // Three-channel single pass: 0, 5, 9
    pulse_start(10'b1000100001);
    do_conv("p0", 12'h111, 2);
    chk("p0_ch", 32'(out_ch), 32'd0);
    chk("p0_data", 32'(out_data), 32'h111);
    chk("p0_valid", 32'(out_valid), 32'h1);
    @(negedge clk);
    chk("p0_next_sel", 32'(chan_sel), 32'h020);
    do_conv("p1", 12'h222, 3);
    chk("p1_ch", 32'(out_ch), 32'd5);
    chk("p1_data", 32'(out_data), 32'h222);
    do_conv("p2", 12'h333, 1);
    chk("p2_ch", 32'(out_ch), 32'd9);
    chk("p2_data", 32'(out_data), 32'h333);
    @(negedge clk);
    chk("pass_end_busy", 32'(busy), 32'h0);
    chk("pass_end_valid", 32'(out_valid), 32'h0);

    // Continuous with mask change mid-pass: 0, 1, then 2 only
    continuous = 1'b1;
    pulse_start(10'b0000000011);
    ch_enable = 10'b0000000100;
    do_conv("c0", 12'h0A0, 1);
    chk("cont_ch0", 32'(out_ch), 32'd0);
    do_conv("c1", 12'h0A1, 1);
    chk("cont_ch1", 32'(out_ch), 32'd1);
    @(negedge clk);
    chk("cont_relatch_sel", 32'(chan_sel), 32'h004);
    continuous = 1'b0;
    do_conv("c2", 12'h0A2, 1);
    chk("cont_ch2", 32'(out_ch), 32'd2);
    chk("cont_data2", 32'(out_data), 32'h0A2);
    @(negedge clk);
    chk("cont_end_busy", 32'(busy), 32'h0);

    // Abort in CONVERT with a coincident conv_done
    pulse_start(10'b0000000001);
    wait_conv_start("ab");
    @(negedge clk);
    conv_done = 1'b1; adc_data = 12'h777; abort = 1'b1;
    @(negedge clk);
    conv_done = 1'b0; abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_valid", 32'(out_valid), 32'h0);
    chk("abort_chan_sel", 32'(chan_sel), 32'h0);
    @(negedge clk);
    chk("abort_valid_later", 32'(out_valid), 32'h0);

    // Reset while holding a sample in OUTPUT
    out_ready = 1'b0;
    pulse_start(10'b0000000010);
    do_conv("rs", 12'hFFF, 1);
    chk("rs_valid_before", 32'(out_valid), 32'h1);
    chk("rs_ch_before", 32'(out_ch), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rs_valid", 32'(out_valid), 32'h0);
    chk("rs_data", 32'(out_data), 32'h0);
    chk("rs_ch", 32'(out_ch), 32'h0);
    chk("rs_busy", 32'(busy), 32'h0);
    chk("rs_chan_sel", 32'(chan_sel), 32'h0);
    chk("rs_conv_start", 32'(conv_start), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
